// File: rtl/voxel_box_fill.sv
// Axis-aligned box fill engine: sweeps every voxel of an inclusive 3-D box
// (z fastest, then y, then x) and emits one memory write per enabled cycle.
module voxel_box_fill #(
  parameter int DATA_WIDTH  = 64,
  parameter int COORD_WIDTH = 6,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x0,
  input  logic [COORD_WIDTH-1:0] cmd_x1,
  input  logic [COORD_WIDTH-1:0] cmd_y0,
  input  logic [COORD_WIDTH-1:0] cmd_y1,
  input  logic [COORD_WIDTH-1:0] cmd_z0,
  input  logic [COORD_WIDTH-1:0] cmd_z1,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  input  logic                   hold,
  input  logic                   abort,
  output logic                   write_en,
  output logic [ADDR_WIDTH-1:0]  write_addr,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             done_status
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_ABORTED = 2'b01;
  localparam logic [1:0] STAT_BAD_BOX = 2'b10;

  localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1'b1);

  logic [1:0]             state_q,  state_d;
  logic [1:0]             status_q, status_d;
  logic                   rdy_q;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [COORD_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [COORD_WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [COORD_WIDTH-1:0] z0_q, z0_d, z1_q, z1_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic                     accept_s;
  logic                     bad_box_s;
  logic [3*COORD_WIDTH-1:0] addr_s;

  // rdy_q keeps cmd_ready low until the first edge after reset releases.
  assign cmd_ready   = rdy_q && (state_q == ST_IDLE);
  assign accept_s    = cmd_valid && cmd_ready;
  assign bad_box_s   = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) || (cmd_z0 > cmd_z1);
  assign write_en    = (state_q == ST_RUN) && !hold && !abort;
  assign addr_s      = {x_q, y_q, z_q};
  assign write_addr  = ADDR_WIDTH'(addr_s);
  assign write_data  = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign done_status = (state_q == ST_DONE) ? status_q : 2'b00;

  // Next-state, sweep counters and command latch.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    z0_d     = z0_q;
    z1_d     = z1_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          x0_d   = cmd_x0;
          x1_d   = cmd_x1;
          y0_d   = cmd_y0;
          y1_d   = cmd_y1;
          z0_d   = cmd_z0;
          z1_d   = cmd_z1;
          data_d = cmd_data;
          x_d    = cmd_x0;
          y_d    = cmd_y0;
          z_d    = cmd_z0;
          if (bad_box_s) begin
            state_d  = ST_DONE;
            status_d = STAT_BAD_BOX;
          end else begin
            state_d  = ST_RUN;
            status_d = STAT_OK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d  = ST_DONE;
          status_d = STAT_ABORTED;
        end else if (hold) begin
          state_d = ST_RUN;
        end else if (z_q != z1_q) begin
          z_d = z_q + COORD_ONE;
        end else begin
          // Wrap compares against the upper bound, so coordinate 63 never overflows.
          z_d = z0_q;
          if (y_q != y1_q) begin
            y_d = y_q + COORD_ONE;
          end else begin
            y_d = y0_q;
            if (x_q != x1_q) begin
              x_d = x_q + COORD_ONE;
            end else begin
              state_d  = ST_DONE;
              status_d = STAT_OK;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      status_q <= STAT_OK;
      rdy_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      z0_q     <= '0;
      z1_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rdy_q    <= 1'b1;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      z0_q     <= z0_d;
      z1_q     <= z1_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: doc/voxel_box_fill.md
VOXEL_BOX_FILL -- requirements
Module: voxel_box_fill

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, voxel word width.
REQ-002 SHALL have parameter COORD_WIDTH, default 6, per-axis coordinate width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 18, equal to 3*COORD_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  box command offered.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have ports cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_z0, cmd_z1  input  COORD_WIDTH each  inclusive box bounds.
REQ-009 SHALL have port cmd_data  input  DATA_WIDTH  value written to every voxel in the box.
REQ-010 SHALL have port hold  input  1  pause sweep, no write while high.
REQ-011 SHALL have port abort  input  1  terminate the current sweep.
REQ-012 SHALL have port write_en  output  1  voxel-memory write strobe.
REQ-013 SHALL have port write_addr  output  ADDR_WIDTH  {x,y,z}: x in [17:12], y in [11:6], z in [5:0].
REQ-014 SHALL have port write_data  output  DATA_WIDTH  latched cmd_data.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port done_status  output  2  00 OK, 01 ABORTED, 10 BAD_BOX; valid only while done=1.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; accept a command on the rising edge where cmd_valid && cmd_ready.
REQ-020 SHALL latch all bounds and cmd_data at acceptance; later changes to the cmd_* inputs SHALL have no effect.
REQ-021 SHALL, at acceptance, go to DONE with status BAD_BOX if x0>x1, y0>y1 or z0>z1, issuing zero writes.
REQ-022 SHALL otherwise go to RUN with counters x=x0, y=y0, z=z0.
REQ-023 SHALL drive write_en = (state==RUN) && !hold && !abort, write_addr={x,y,z}, write_data=latched data.
REQ-024 SHALL issue the first write in the cycle immediately after acceptance (latency 1) if hold and abort are low.
REQ-025 SHALL, on each edge where write_en=1, advance z first; z=z1 wraps to z0 and increments y; y=y1 wraps to y0 and increments x.
REQ-026 SHALL, on the edge committing the write at (x1,y1,z1), go to DONE with status OK.
REQ-027 SHALL freeze the counters and state on every RUN cycle with hold=1 and abort=0.
REQ-028 SHALL, when abort=1 in RUN, suppress that cycle's write and go to DONE with status ABORTED, regardless of hold.
REQ-029 SHALL ignore abort and hold outside RUN.
REQ-030 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE; cmd_ready SHALL stay low in DONE.
REQ-031 SHALL issue exactly (x1-x0+1)*(y1-y0+1)*(z1-z0+1) writes for an unaborted valid box, up to 262,144 for the full grid, with no counter overflow at coordinate 63.
REQ-032 SHALL never assert write_en to an address outside the latched box.

Reset
REQ-033 SHALL, while rst=1, hold state IDLE, with write_en=0, done=0, done_status=00, busy=0, cmd_ready=0, write_addr=0 and write_data=0.
REQ-034 SHALL, on assertion of rst mid-sweep, drop write_en immediately and produce no done pulse.
REQ-035 SHALL raise cmd_ready on the first clk edge after rst deasserts.

Verification
REQ-036 Box x0=x1=2, y0=y1=3, z0=5, z1=7, data=0xA5 -> writes on 3 consecutive cycles to 0x20C5, 0x20C6, 0x20C7, then done=1 with status 00.
REQ-037 Box 0..1 on every axis -> 8 writes in order 0x00000, 0x00001, 0x00040, 0x00041, 0x01000, 0x01001, 0x01040, 0x01041; done on cycle 9 after acceptance.
REQ-038 Box z0=4, z1=3 -> no write_en, done=1 with status 10 on the cycle after acceptance.
REQ-039 4-voxel box with hold=1 for 3 cycles after the second write -> exactly 4 writes, in order with none repeated, and done 8 cycles after acceptance.
REQ-040 Full box 0..63 on every axis with abort=1 at the 100th RUN cycle -> exactly 99 writes, the last to 0x00062, then status 01.
REQ-041 rst pulsed mid-sweep, then a new 1-voxel box -> no done for the first box; second box writes once and reports status 00.
